cci_mpf_shim_unpack_wrrsp_from_fiu: RTL and testbench

// Canonicalizes c1Rx write responses as they enter MPF from the system interface on the way to user code.

---
 rtl/cci_mpf_shim_unpack_wrrsp_from_fiu.sv | 165 ++++++++++++++++
 tb/tb_cci_mpf_shim_unpack_wrrsp_from_fiu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_unpack_wrrsp_from_fiu.sv
// rtl/cci_mpf_shim_unpack_wrrsp_from_fiu.sv - expands packed FIU write responses into single-line responses
//
// Purpose: c1Rx write responses from the FIU are written into a response FIFO.
// An expander then turns each entry into one response per line, so downstream
// logic never sees a packed response. FIU responses cannot be back-pressured,
// so the FIFO almost-full is folded into the AFU-facing c1Tx almost-full.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   fiu_c1Rx_valid/mdata/format/cl_num  write response from the FIU
//   fiu_c1TxAlmFull                 FIU request-channel almost-full
//   afu_c1Rx_valid/mdata/format/cl_num  canonical single-line response (registered)
//   afu_c1TxAlmFull                 fiu_c1TxAlmFull | FIFO almost-full
//   err_overflow                    sticky: a response was dropped on a full FIFO
module cci_mpf_shim_unpack_wrrsp_from_fiu #(
  parameter int MDATA_W         = 16,
  parameter int FIFO_DEPTH      = 32,
  parameter int ALM_FULL_THRESH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fiu_c1Rx_valid,
  input  logic [MDATA_W-1:0] fiu_c1Rx_mdata,
  input  logic               fiu_c1Rx_format,
  input  logic [1:0]         fiu_c1Rx_cl_num,
  input  logic               fiu_c1TxAlmFull,
  output logic               afu_c1Rx_valid,
  output logic [MDATA_W-1:0] afu_c1Rx_mdata,
  output logic               afu_c1Rx_format,
  output logic [1:0]         afu_c1Rx_cl_num,
  output logic               afu_c1TxAlmFull,
  output logic               err_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = MDATA_W + 3;
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   OCC_ALM  = (PTR_W+1)'(FIFO_DEPTH - ALM_FULL_THRESH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Response FIFO storage; entry = {mdata, format, cl_num}
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  logic             empty;
  logic             full;
  logic             push_ok;
  logic             pop;

  state_t           state;
  logic [1:0]       idx;

  logic [ENT_W-1:0]   head;
  logic [MDATA_W-1:0] head_mdata;
  logic               head_format;
  logic [1:0]         head_cl_num;
  logic [1:0]         last;
  logic [1:0]         out_idx;

  assign empty = (occ == '0);
  assign full  = (occ == OCC_FULL);

  assign head        = mem[rd_ptr];
  assign head_mdata  = head[ENT_W-1:3];
  assign head_format = head[2];
  assign head_cl_num = head[1:0];

  // A packed entry covers lines 0..cl_num; an unpacked one is a single beat
  // that keeps its own line index.
  assign last    = head_format ? head_cl_num : 2'd0;
  assign out_idx = head_format ? idx : head_cl_num;

  // The head leaves the FIFO on the cycle its final beat is emitted, so the
  // next entry starts on the following cycle without a bubble.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE)
        pop = (last == 2'd0);
      else
        pop = (idx == last);
    end
  end

  // A full FIFO can still accept when the head pops in the same cycle.
  assign push_ok = fiu_c1Rx_valid && (!full || pop);

  assign afu_c1TxAlmFull = fiu_c1TxAlmFull || (occ >= OCC_ALM);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {fiu_c1Rx_mdata, fiu_c1Rx_format, fiu_c1Rx_cl_num};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Expander FSM with registered beat outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= 2'd0;
      afu_c1Rx_valid  <= 1'b0;
      afu_c1Rx_mdata  <= '0;
      afu_c1Rx_format <= 1'b0;
      afu_c1Rx_cl_num <= 2'd0;
      err_overflow    <= 1'b0;
    end else begin
      afu_c1Rx_valid  <= !empty;
      afu_c1Rx_format <= 1'b0;
      if (!empty) begin
        afu_c1Rx_mdata  <= head_mdata;
        afu_c1Rx_cl_num <= out_idx;
      end

      if (fiu_c1Rx_valid && !push_ok)
        err_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (!empty && (last != 2'd0)) begin
            idx   <= 2'd1;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          if (idx == last) begin
            idx   <= 2'd0;
            state <= IDLE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
          idx   <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_unpack_wrrsp_from_fiu.sv
// tb/tb_cci_mpf_shim_unpack_wrrsp_from_fiu.sv - self-checking bench for the write-response unpacker
module tb_cci_mpf_shim_unpack_wrrsp_from_fiu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fiu_c1Rx_valid = 1'b0;
  logic [15:0] fiu_c1Rx_mdata = '0;
  logic        fiu_c1Rx_format = 1'b0;
  logic [1:0]  fiu_c1Rx_cl_num = '0;
  logic        fiu_c1TxAlmFull = 1'b0;
  logic        afu_c1Rx_valid;
  logic [15:0] afu_c1Rx_mdata;
  logic        afu_c1Rx_format;
  logic [1:0]  afu_c1Rx_cl_num;
  logic        afu_c1TxAlmFull;
  logic        err_overflow;

  cci_mpf_shim_unpack_wrrsp_from_fiu dut (
    .clk             (clk),
    .reset           (reset),
    .fiu_c1Rx_valid  (fiu_c1Rx_valid),
    .fiu_c1Rx_mdata  (fiu_c1Rx_mdata),
    .fiu_c1Rx_format (fiu_c1Rx_format),
    .fiu_c1Rx_cl_num (fiu_c1Rx_cl_num),
    .fiu_c1TxAlmFull (fiu_c1TxAlmFull),
    .afu_c1Rx_valid  (afu_c1Rx_valid),
    .afu_c1Rx_mdata  (afu_c1Rx_mdata),
    .afu_c1Rx_format (afu_c1Rx_format),
    .afu_c1Rx_cl_num (afu_c1Rx_cl_num),
    .afu_c1TxAlmFull (afu_c1TxAlmFull),
    .err_overflow    (err_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: a queue of pending responses; the head is consumed one
  // line per clock, and its beat appears on the outputs after that clock.
  typedef struct {
    logic [15:0] md;
    logic        f;
    logic [1:0]  cl;
  } rsp_t;

  rsp_t        q[$];
  int          bidx = 0;
  logic        exp_valid = 0;
  logic [15:0] exp_md = 0;
  logic [1:0]  exp_cl = 0;
  logic        exp_ovf = 0;

  function automatic int nbeats(rsp_t r);
    return r.f ? int'(r.cl) + 1 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    bidx = 0;
    exp_valid = 0;
    exp_md = 0;
    exp_cl = 0;
    exp_ovf = 0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] md, input logic f, input logic [1:0] cl);
    logic popped;
    rsp_t r;
    popped = 0;
    if (q.size() > 0) begin
      exp_valid = 1;
      exp_md = q[0].md;
      exp_cl = q[0].f ? 2'(bidx) : q[0].cl;
      bidx++;
      if (bidx == nbeats(q[0])) begin
        void'(q.pop_front());
        bidx = 0;
        popped = 1;
      end
    end else begin
      exp_valid = 0;
    end
    if (v) begin
      if (q.size() < 32 || popped) begin
        r.md = md; r.f = f; r.cl = cl;
        q.push_back(r);
      end else begin
        exp_ovf = 1;
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".valid"}, 32'(afu_c1Rx_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk({tag, ".mdata"}, 32'(afu_c1Rx_mdata), 32'(exp_md));
      chk({tag, ".cl_num"}, 32'(afu_c1Rx_cl_num), 32'(exp_cl));
    end
    chk({tag, ".format"}, 32'(afu_c1Rx_format), 32'd0);
    chk({tag, ".almfull"}, 32'(afu_c1TxAlmFull), 32'(fiu_c1TxAlmFull || (q.size() >= 24)));
    chk({tag, ".ovf"}, 32'(err_overflow), 32'(exp_ovf));
  endtask

  // Drive one cycle of input, advance DUT and model across the edge, compare.
  task automatic step(input string tag, input logic v, input logic [15:0] md,
                      input logic f, input logic [1:0] cl);
    fiu_c1Rx_valid  = v;
    fiu_c1Rx_mdata  = md;
    fiu_c1Rx_format = f;
    fiu_c1Rx_cl_num = cl;
    @(posedge clk);
    model_edge(v, md, f, cl);
    #1;
    compare(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0, 1'b0, 2'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".valid"}, 32'(afu_c1Rx_valid), 32'd0);
    chk({tag, ".mdata"}, 32'(afu_c1Rx_mdata), 32'd0);
    chk({tag, ".cl_num"}, 32'(afu_c1Rx_cl_num), 32'd0);
    chk({tag, ".format"}, 32'(afu_c1Rx_format), 32'd0);
    chk({tag, ".ovf"}, 32'(err_overflow), 32'd0);
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("reset_async");
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int hits;
    logic will_pop;
    logic v;

    // Power-on reset
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle("post_por", 3);

    // Unpacked single line keeps its own line index
    step("unpacked", 1'b1, 16'h0012, 1'b0, 2'd2);
    idle("unpacked_out", 4);

    // Packed four-line response
    step("packed4", 1'b1, 16'h00A5, 1'b1, 2'd3);
    idle("packed4_out", 7);

    // Packed cl_num=0 is a single beat
    step("packed1", 1'b1, 16'h0BEE, 1'b1, 2'd0);
    idle("packed1_out", 3);

    // Eight back-to-back packed-4 responses
    for (int i = 0; i < 8; i++) step("burst8", 1'b1, 16'(i), 1'b1, 2'd3);
    idle("burst8_drain", 36);

    // Overflow: 48 back-to-back packed-4 responses
    for (int i = 0; i < 48; i++) step("ovf_fill", 1'b1, 16'(16'h100 + i), 1'b1, 2'd3);
    idle("ovf_drain", 190);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    // Reset during an expansion clears the outputs and abandons it
    apply_reset();
    idle("rst_idle", 2);
    step("rst_mid_in", 1'b1, 16'h5A5A, 1'b1, 2'd3);
    idle("rst_mid_beats", 2);
    apply_reset();
    idle("after_rst", 6);
    step("after_rst_in", 1'b1, 16'h7777, 1'b0, 2'd1);
    idle("after_rst_out", 3);

    // FIU almost-full passes straight through with an empty FIFO
    #1;
    fiu_c1TxAlmFull = 1'b1;
    #1;
    chk("almfull_pass_hi", 32'(afu_c1TxAlmFull), 32'd1);
    fiu_c1TxAlmFull = 1'b0;
    #1;
    chk("almfull_pass_lo", 32'(afu_c1TxAlmFull), 32'd0);

    // Keep the FIFO full and push only when full coincides with a pop
    hits = 0;
    for (int i = 0; i < 90; i++) begin
      will_pop = (q.size() > 0) && (bidx + 1 == nbeats(q[0]));
      v = (q.size() < 32) || will_pop;
      if (v && q.size() == 32) hits++;
      step("full_pushpop", v, 16'(16'h200 + i), 1'b1, 2'd3);
    end
    chk("full_pushpop_seen", 32'(hits > 0), 32'd1);
    idle("full_pushpop_drain", 140);

    // Randomized traffic with random FIU almost-full
    for (int i = 0; i < 400; i++) begin
      fiu_c1TxAlmFull = ($urandom_range(0, 7) == 0);
      step("random", ($urandom_range(0, 9) < 3), 16'($urandom), 1'($urandom), 2'($urandom));
    end
    fiu_c1TxAlmFull = 1'b0;
    idle("random_drain", 120);
    chk("random_empty", 32'(afu_c1Rx_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
